// File: rtl/cas_pkg.sv
// Shared types and defaults for the Colour Genie cassette transmitter.
package cas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEADER,
      ST_SYNC,
      ST_DATA,
      ST_TAIL
   } cas_state_t;

   localparam int         CAS_CELL_TICKS   = 924;
   localparam int         CAS_PULSE_TICKS  = 110;
   localparam int         CAS_LEADER_COUNT = 255;
   localparam logic [7:0] CAS_LEADER_BYTE  = 8'hAA;
   localparam logic [7:0] CAS_SYNC_BYTE    = 8'h66;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int cas_cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cas_bitcell.sv
// One pulse-coded bit cell: clock pulse at tick 0, extra data pulse mid-cell for a 1.
// Legal timing: CELL_TICKS >= 4 and PULSE_TICKS < CELL_TICKS/2.
module cas_bitcell
   import cas_pkg::*;
#(
   parameter int CELL_TICKS  = CAS_CELL_TICKS,
   parameter int PULSE_TICKS = CAS_PULSE_TICKS
) (
   input  logic clock,
   input  logic reset,
   input  logic ce,
   input  logic run,
   input  logic mute,
   input  logic abort,
   input  logic bit_val,
   output logic tape,
   output logic cell_done
);

   localparam int            TW         = cas_cnt_width(CELL_TICKS);
   localparam logic [TW-1:0] TICK_LAST  = TW'(CELL_TICKS - 1);
   localparam logic [TW-1:0] PULSE_END  = TW'(PULSE_TICKS);
   localparam logic [TW-1:0] DATA_START = TW'(CELL_TICKS / 2);
   localparam logic [TW-1:0] DATA_END   = TW'(CELL_TICKS / 2 + PULSE_TICKS);

   logic [TW-1:0] tick;
   logic          level;

   // NOTE: level gets a default before any condition so this block never infers a latch.
   always_comb begin
      level = 1'b0;
      if (!mute)
         level = (tick < PULSE_END) ||
                 (bit_val && (tick >= DATA_START) && (tick < DATA_END));
   end

   assign cell_done = ce & run & (tick == TICK_LAST);

   // Each ce emits the level for the current tick, then advances; a stalled cell holds tick 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick <= '0;
         tape <= 1'b0;
      end else if (abort) begin
         tick <= '0;
         tape <= 1'b0;
      end else if (ce) begin
         if (run) begin
            tape <= level;
            tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
         end else begin
            tape <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cas_player.sv
// Cassette transmitter: leader, sync byte, then handshaked data bytes, then a silent tail cell.
module cas_player
   import cas_pkg::*;
#(
   parameter int         CELL_TICKS   = CAS_CELL_TICKS,
   parameter int         PULSE_TICKS  = CAS_PULSE_TICKS,
   parameter int         LEADER_BYTES = CAS_LEADER_COUNT,
   parameter logic [7:0] SYNC_BYTE    = CAS_SYNC_BYTE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       last,
   output logic       ready,
   output logic       tape,
   output logic       busy,
   output logic       underrun
);

   localparam int            LW        = cas_cnt_width(LEADER_BYTES);
   localparam logic [LW-1:0] LEAD_LAST = LW'(LEADER_BYTES - 1);

   cas_state_t    state;
   logic [7:0]    hold_data;
   logic          hold_last;
   logic          hold_full;
   logic [7:0]    shift_byte;
   logic [2:0]    bit_idx;
   logic [LW-1:0] lead_cnt;
   logic          last_sent;
   logic          starved;

   logic          xfer;
   logic          next_avail;
   logic [7:0]    next_byte;
   logic          next_last;
   logic          cell_run;
   logic          cell_done;
   logic          boundary;
   logic          resume;
   logic          take;

   assign ready = ((state == ST_LEADER) || (state == ST_SYNC) || (state == ST_DATA)) && !hold_full;
   assign xfer  = valid & ready;

   // A byte accepted on this very edge counts as already held.
   assign next_avail = hold_full | xfer;
   assign next_byte  = hold_full ? hold_data : data;
   assign next_last  = hold_full ? hold_last : last;

   assign boundary = cell_done && (bit_idx == 3'd0) && ((state == ST_SYNC) || (state == ST_DATA));
   assign resume   = starved && ce && next_avail;
   assign take     = resume || (boundary && next_avail);
   assign cell_run = (state != ST_IDLE) && (!starved || next_avail);

   cas_bitcell #(
      .CELL_TICKS (CELL_TICKS),
      .PULSE_TICKS(PULSE_TICKS)
   ) u_bitcell (
      .clock    (clock),
      .reset    (reset),
      .ce       (ce),
      .run      (cell_run),
      .mute     (state == ST_TAIL),
      .abort    (stop),
      .bit_val  (shift_byte[bit_idx]),
      .tape     (tape),
      .cell_done(cell_done)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         underrun   <= 1'b0;
         hold_data  <= '0;
         hold_last  <= 1'b0;
         hold_full  <= 1'b0;
         shift_byte <= '0;
         bit_idx    <= 3'd7;
         lead_cnt   <= '0;
         last_sent  <= 1'b0;
         starved    <= 1'b0;
      end else if (stop) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         hold_full <= 1'b0;
         bit_idx   <= 3'd7;
         lead_cnt  <= '0;
         last_sent <= 1'b0;
         starved   <= 1'b0;
      end else begin
         if (take) begin
            hold_full <= 1'b0;
         end else if (xfer) begin
            hold_data <= data;
            hold_last <= last;
            hold_full <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= (LEADER_BYTES == 0) ? ST_SYNC : ST_LEADER;
                  shift_byte <= (LEADER_BYTES == 0) ? SYNC_BYTE : CAS_LEADER_BYTE;
                  busy       <= 1'b1;
                  bit_idx    <= 3'd7;
                  lead_cnt   <= '0;
                  underrun   <= 1'b0;
                  last_sent  <= 1'b0;
                  starved    <= 1'b0;
               end
            end
            ST_LEADER: begin
               if (cell_done) begin
                  if (bit_idx != 3'd0) begin
                     bit_idx <= bit_idx - 1'b1;
                  end else begin
                     bit_idx <= 3'd7;
                     if (lead_cnt == LEAD_LAST) begin
                        state      <= ST_SYNC;
                        shift_byte <= SYNC_BYTE;
                        lead_cnt   <= '0;
                     end else begin
                        lead_cnt <= lead_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_SYNC, ST_DATA: begin
               if (resume) begin
                  shift_byte <= next_byte;
                  last_sent  <= next_last;
                  starved    <= 1'b0;
               end else if (cell_done) begin
                  if (bit_idx != 3'd0) begin
                     bit_idx <= bit_idx - 1'b1;
                  end else begin
                     bit_idx <= 3'd7;
                     if (next_avail) begin
                        state      <= ST_DATA;
                        shift_byte <= next_byte;
                        last_sent  <= next_last;
                     end else if (last_sent) begin
                        state <= ST_TAIL;
                     end else begin
                        // Stall with tick parked at 0 until a byte shows up.
                        state    <= ST_DATA;
                        starved  <= 1'b1;
                        underrun <= 1'b1;
                     end
                  end
               end
            end
            ST_TAIL: begin
               if (cell_done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player: compares the tape trace cell by cell against hand-computed patterns.
module tb_cas_player;

   localparam int          CELL       = 20;
   // 20 ticks, first tick in the MSB: clock pulse ticks 0-2, data pulse ticks 10-12.
   localparam logic [19:0] CELL_ONE   = 20'hE0380;
   localparam logic [19:0] CELL_ZERO  = 20'hE0000;
   localparam logic [19:0] CELL_QUIET = 20'h00000;

   logic       clock = 1'b0;
   logic       reset;
   logic       ce;
   logic       start;
   logic       stop;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       ready;
   logic       tape;
   logic       busy;
   logic       underrun;

   cas_player #(
      .CELL_TICKS  (20),
      .PULSE_TICKS (3),
      .LEADER_BYTES(2),
      .SYNC_BYTE   (8'h66)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .ce      (ce),
      .start   (start),
      .stop    (stop),
      .data    (data),
      .valid   (valid),
      .last    (last),
      .ready   (ready),
      .tape    (tape),
      .busy    (busy),
      .underrun(underrun)
   );

   always #5 clock = ~clock;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc = 0;
   int          ce_period = 1;
   int          poke_start = -1;
   int          poke_stop  = -1;
   int          xfers = 0;
   int          lag = 0;
   int          n_in_cell = 0;
   int          cells_seen = 0;
   logic        quiet_or = 1'b0;
   logic        rec_on = 1'b0;
   logic        last_ce = 1'b0;
   logic [19:0] cell_bits = '0;
   string       scen = "reset";
   logic [7:0]  src_data[$];
   logic        src_last[$];
   logic [19:0] exp_cells[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic expect_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         exp_cells.push_back(b[i] ? CELL_ONE : CELL_ZERO);
   endtask

   task automatic expect_head();
      expect_byte(8'hAA);
      expect_byte(8'hAA);
      expect_byte(8'h66);
   endtask

   task automatic push_src(input logic [7:0] b, input logic l);
      src_data.push_back(b);
      src_last.push_back(l);
   endtask

   // One clock: drive inputs, take the edge, account transfers and record the tape sample.
   task automatic clk_step();
      logic        ce_now;
      logic        xfer_now;
      logic [7:0]  d_tmp;
      logic        l_tmp;
      logic [19:0] want;
      ce_now = (cyc % ce_period) == 0;
      ce     = ce_now;
      start  = (cyc == poke_start);
      stop   = (cyc == poke_stop);
      valid  = src_data.size() > 0;
      if (valid) begin
         data = src_data[0];
         last = src_last[0];
      end
      xfer_now = valid && ready;
      @(posedge clock);
      #1;
      cyc++;
      last_ce = ce_now;
      if (xfer_now) begin
         d_tmp = src_data.pop_front();
         l_tmp = src_last.pop_front();
         xfers++;
      end
      if (exp_cells.size() == 0) begin
         quiet_or = quiet_or | tape;
      end else if (rec_on && ce_now) begin
         cell_bits = {cell_bits[18:0], tape};
         n_in_cell++;
         if (n_in_cell == CELL) begin
            want = exp_cells.pop_front();
            check($sformatf("%s_cell%0d", scen, cells_seen), 32'(cell_bits), 32'(want));
            cells_seen++;
            n_in_cell = 0;
         end
      end
      if (rec_on && ce_now && exp_cells.size() == 0 && busy)
         lag++;
   endtask

   task automatic do_start();
      rec_on     = 1'b0;
      poke_start = cyc;
      clk_step();
      rec_on     = 1'b1;
      lag        = 0;
      n_in_cell  = 0;
      cells_seen = 0;
      quiet_or   = 1'b0;
   endtask

   task automatic do_stop();
      poke_stop = cyc;
      clk_step();
   endtask

   task automatic run_ces(input int n);
      int k;
      k = 0;
      while (k < n) begin
         clk_step();
         if (last_ce) k++;
      end
   endtask

   task automatic run_until_idle(input int budget);
      int steps;
      steps = 0;
      while (busy && steps < budget) begin
         clk_step();
         steps++;
      end
      check({scen, "_idle"}, 32'(busy), 32'd0);
      check({scen, "_cells_left"}, 32'(exp_cells.size()), 32'd0);
      check({scen, "_idle_lag"}, 32'(lag), 32'd0);
      exp_cells.delete();
   endtask

   initial begin
      reset = 1'b0;
      ce    = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      data  = 8'h00;
      valid = 1'b0;
      last  = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_tape", 32'(tape), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      reset = 1'b1;
      repeat (3) clk_step();

      // Single preloaded last byte: AA,AA,66,80 then a silent tail cell
      scen = "s2";
      push_src(8'h80, 1'b1);
      expect_head();
      expect_byte(8'h80);
      exp_cells.push_back(CELL_QUIET);
      do_start();
      check("s2_busy", 32'(busy), 32'd1);
      check("s2_ready", 32'(ready), 32'd1);
      run_until_idle(2000);

      // Back-to-back stream with valid held
      scen  = "s3";
      xfers = 0;
      push_src(8'h00, 1'b0);
      push_src(8'hFF, 1'b1);
      expect_head();
      expect_byte(8'h00);
      expect_byte(8'hFF);
      exp_cells.push_back(CELL_QUIET);
      do_start();
      run_until_idle(2000);
      check("s3_xfers", 32'(xfers), 32'd2);
      check("s3_underrun", 32'(underrun), 32'd0);

      // Data withheld past the sync byte
      scen = "s4";
      expect_head();
      do_start();
      run_ces(24 * CELL + 50);
      check("s4_underrun", 32'(underrun), 32'd1);
      check("s4_quiet", 32'(quiet_or), 32'd0);
      check("s4_busy", 32'(busy), 32'd1);
      lag = 0;
      expect_byte(8'h01);
      exp_cells.push_back(CELL_QUIET);
      push_src(8'h01, 1'b1);
      run_until_idle(2000);
      check("s4_underrun_sticky", 32'(underrun), 32'd1);

      // Stop in tick 11 of the first (bit 1) leader cell, with a byte preloaded
      scen = "s5";
      push_src(8'h55, 1'b1);
      do_start();
      check("s5_underrun_cleared", 32'(underrun), 32'd0);
      run_ces(12);
      check("s5_tape_tick11", 32'(tape), 32'd1);
      do_stop();
      check("s5_stop_tape", 32'(tape), 32'd0);
      check("s5_stop_busy", 32'(busy), 32'd0);
      check("s5_stop_ready", 32'(ready), 32'd0);
      scen = "s5b";
      push_src(8'hC3, 1'b1);
      expect_head();
      expect_byte(8'hC3);
      exp_cells.push_back(CELL_QUIET);
      do_start();
      run_until_idle(2000);

      // Reset mid-DATA, then no activity until a new start
      scen = "s1";
      push_src(8'h80, 1'b1);
      expect_head();
      expect_byte(8'h80);
      exp_cells.push_back(CELL_QUIET);
      do_start();
      run_ces(24 * CELL + 30);
      #2 reset = 1'b0;
      @(posedge clock);
      #1;
      check("s1_rst_tape", 32'(tape), 32'd0);
      check("s1_rst_busy", 32'(busy), 32'd0);
      check("s1_rst_ready", 32'(ready), 32'd0);
      reset = 1'b1;
      exp_cells.delete();
      src_data.delete();
      src_last.delete();
      quiet_or = 1'b0;
      repeat (60) clk_step();
      check("s1_stays_idle", 32'(busy), 32'd0);
      check("s1_quiet", 32'(quiet_or), 32'd0);

      // Sparse ce (1 in 32): same trace as s2 counted in ce ticks; start while busy ignored
      scen      = "s6";
      ce_period = 32;
      push_src(8'h80, 1'b1);
      expect_head();
      expect_byte(8'h80);
      exp_cells.push_back(CELL_QUIET);
      do_start();
      poke_start = cyc + 3000;
      run_until_idle(30000);
      ce_period = 1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
